// File: rtl/pixel_pkg.sv
// Shared geometry defaults, colour packing and controller state encoding
// for the double-buffered HUB75-style pixel framebuffer.
package pixel_pkg;
   localparam int DEF_COLS  = 64;
   localparam int DEF_ROWS  = 64;
   localparam int DEF_CBITS = 4;
   localparam int DEF_CW    = 3 * DEF_CBITS;

   typedef struct packed {
      logic [DEF_CBITS-1:0] r;
      logic [DEF_CBITS-1:0] g;
      logic [DEF_CBITS-1:0] b;
   } rgb_t;

   typedef enum logic {
      ST_IDLE,
      ST_CLEAR
   } clr_state_t;
endpackage

// File: rtl/fb_bank.sv
// One half-panel of one bank: simple dual-port RAM, one write port and one
// registered synchronous read port, so it maps onto block RAM.
module fb_bank #(
   parameter int W     = 12,
   parameter int DEPTH = 2048,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rd_data
);
   logic [W-1:0] mem [DEPTH];
   logic [W-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rd_data_q <= mem[raddr];
   end

   assign rd_data = rd_data_q;
endmodule

// File: rtl/pixel_framebuffer.sv
// Double-buffered panel framebuffer: writes/clears go to the back bank, the
// panel driver reads bit planes of the front bank; swaps happen at frame_end.
module pixel_framebuffer
   import pixel_pkg::*;
#(
   parameter int COLS  = DEF_COLS,
   parameter int ROWS  = DEF_ROWS,
   parameter int CBITS = DEF_CBITS,
   parameter int CW    = 3 * CBITS
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      wr_valid,
   output logic                      wr_ready,
   input  logic [$clog2(COLS)-1:0]   wr_x,
   input  logic [$clog2(ROWS)-1:0]   wr_y,
   input  logic [CW-1:0]             wr_color,
   input  logic                      clr_start,
   input  logic [CW-1:0]             clr_color,
   output logic                      clr_busy,
   input  logic                      swap_req,
   input  logic                      frame_end,
   output logic                      swap_pending,
   output logic                      front_sel,
   input  logic                      rd_en,
   input  logic [$clog2(COLS)-1:0]   col_addr,
   input  logic [$clog2(ROWS)-2:0]   row_addr,
   input  logic [$clog2(CBITS)-1:0]  bcm_phase,
   output logic                      rd_valid,
   output logic                      R1,
   output logic                      G1,
   output logic                      B1,
   output logic                      R2,
   output logic                      G2,
   output logic                      B2
);
   localparam int XW    = $clog2(COLS);
   localparam int YW    = $clog2(ROWS);
   localparam int HYW   = YW - 1;
   localparam int AW    = HYW + XW;
   localparam int DEPTH = (ROWS / 2) << XW;
   localparam int PW    = $clog2(CBITS);
   localparam logic [XW:0] COLS_L = (XW + 1)'(COLS);

   clr_state_t       state_q, state_d;
   logic [XW-1:0]    cx_q, cx_d;
   logic [HYW-1:0]   cy_q, cy_d;
   logic [CW-1:0]    clr_color_q, clr_color_d;
   logic             front_q, front_d;
   logic             pend_q, pend_d;
   logic             rv1_q, rv1_d;
   logic [PW-1:0]    ph1_q, ph1_d;
   logic             bank1_q, bank1_d;
   logic             rd_valid_q, rd_valid_d;
   logic [5:0]       out_q, out_d;

   logic             wr_fire;
   logic [CW-1:0]    rd_data [2][2];
   logic [CW-1:0]    top, bot;
   logic [CBITS-1:0] top_r, top_g, top_b, bot_r, bot_g, bot_b;

   assign clr_busy = (state_q == ST_CLEAR);
   assign wr_ready = rst_n & ~clr_busy;
   // Out-of-range columns are handshaken but never reach the RAM.
   assign wr_fire  = wr_valid & wr_ready & ({1'b0, wr_x} < COLS_L);

   always_comb begin
      state_d     = state_q;
      cx_d        = cx_q;
      cy_d        = cy_q;
      clr_color_d = clr_color_q;
      case (state_q)
         ST_IDLE: begin
            if (clr_start) begin
               state_d     = ST_CLEAR;
               cx_d        = '0;
               cy_d        = '0;
               clr_color_d = clr_color;
            end
         end
         ST_CLEAR: begin
            if (cx_q == XW'(COLS - 1)) begin
               cx_d = '0;
               if (cy_q == HYW'(ROWS / 2 - 1)) state_d = ST_IDLE;
               else                            cy_d    = cy_q + HYW'(1);
            end else begin
               cx_d = cx_q + XW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      front_d = front_q;
      pend_d  = pend_q;
      if (frame_end && (pend_q || swap_req) && !clr_busy) begin
         front_d = ~front_q;
         pend_d  = 1'b0;
      end else if (swap_req) begin
         pend_d = 1'b1;
      end
   end

   genvar gi, gj;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_bank
         for (gj = 0; gj < 2; gj++) begin : g_half
            logic          we;
            logic [AW-1:0] waddr;
            logic [CW-1:0] wdata;
            assign we    = (front_q != 1'(gi)) &&
                           (clr_busy || (wr_fire && (wr_y[YW-1] == 1'(gj))));
            assign waddr = clr_busy ? {cy_q, cx_q} : {wr_y[HYW-1:0], wr_x};
            assign wdata = clr_busy ? clr_color_q : wr_color;

            fb_bank #(.W(CW), .DEPTH(DEPTH), .AW(AW)) u_bank (
               .clk     (clk),
               .we      (we),
               .waddr   (waddr),
               .wdata   (wdata),
               .re      (rd_en),
               .raddr   ({row_addr, col_addr}),
               .rd_data (rd_data[gi][gj])
            );
         end
      end
   endgenerate

   // Bank choice is the front_sel captured with the request, not the live one.
   assign top   = bank1_q ? rd_data[1][0] : rd_data[0][0];
   assign bot   = bank1_q ? rd_data[1][1] : rd_data[0][1];
   assign top_r = top[CW-1 -: CBITS];
   assign top_g = top[2*CBITS-1 -: CBITS];
   assign top_b = top[CBITS-1:0];
   assign bot_r = bot[CW-1 -: CBITS];
   assign bot_g = bot[2*CBITS-1 -: CBITS];
   assign bot_b = bot[CBITS-1:0];

   always_comb begin
      rv1_d      = rd_en;
      ph1_d      = bcm_phase;
      bank1_d    = front_q;
      rd_valid_d = rv1_q;
      out_d      = out_q;
      if (rv1_q) begin
         out_d = {top_r[ph1_q], top_g[ph1_q], top_b[ph1_q],
                  bot_r[ph1_q], bot_g[ph1_q], bot_b[ph1_q]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cx_q        <= '0;
         cy_q        <= '0;
         clr_color_q <= '0;
         front_q     <= 1'b0;
         pend_q      <= 1'b0;
         rv1_q       <= 1'b0;
         ph1_q       <= '0;
         bank1_q     <= 1'b0;
         rd_valid_q  <= 1'b0;
         out_q       <= '0;
      end else begin
         state_q     <= state_d;
         cx_q        <= cx_d;
         cy_q        <= cy_d;
         clr_color_q <= clr_color_d;
         front_q     <= front_d;
         pend_q      <= pend_d;
         rv1_q       <= rv1_d;
         ph1_q       <= ph1_d;
         bank1_q     <= bank1_d;
         rd_valid_q  <= rd_valid_d;
         out_q       <= out_d;
      end
   end

   assign swap_pending = pend_q;
   assign front_sel    = front_q;
   assign rd_valid     = rd_valid_q;
   assign {R1, G1, B1, R2, G2, B2} = out_q;
endmodule
